// File: rtl/lockpick_result_capture.sv
`default_nettype none
// ============================================================================
//  Module   : lockpick_result_capture
//  Purpose  : Buffers the lockpick core's result burst, classifies it into a
//             verdict, keeps saturating verdict statistics and replays the
//             buffered bytes to the host over a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module lockpick_result_capture #(
  parameter int NBYTES = 32,   // burst length; the patterns repeat every 4 bytes
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [1:0]       in_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             verdict_valid,
  output logic [2:0]       verdict,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] lock_cnt,
  output logic [CNT_W-1:0] corrupt_cnt,
  output logic             overrun,
  input  logic             clr_stats
);

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] c_last = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_REPLAY} state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx, r_rd_idx, w_wr_idx;
  logic [7:0]       r_buf [NBYTES];
  logic [1:0]       r_status;
  logic             w_store, w_short, w_check, w_xfer, w_drop, w_update;
  logic             w_is_win, w_is_err, w_is_lock;
  logic [2:0]       w_class, w_new_verdict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State register; reset aborts any burst or replay in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus the per-cycle event strobes used by the datapath.
  always_comb begin
    w_next  = r_state;
    w_store = 1'b0;
    w_short = 1'b0;
    w_check = 1'b0;
    w_xfer  = 1'b0;
    w_drop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_store = 1'b1;
          w_next  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          w_store = 1'b1;
          if (r_idx == c_last) w_next = S_CHECK;
        end else begin
          w_short = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_CHECK: begin
        w_check = 1'b1;
        w_drop  = in_valid;
        w_next  = S_REPLAY;
      end
      S_REPLAY: begin
        w_drop = in_valid;
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_rd_idx == c_last) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wr_idx  = (r_state == S_IDLE) ? '0 : r_idx;
  assign out_valid = (r_state == S_REPLAY);
  assign out_data  = r_buf[r_rd_idx];

  // Burst storage; contents are meaningless until a burst has been captured.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[w_wr_idx] <= in_data;
  end

  // Write/read indices and the status sampled alongside the final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_rd_idx <= '0;
      r_status <= 2'b00;
    end else begin
      if (w_store) begin
        r_idx <= (r_state == S_IDLE) ? IDX_W'(1) : r_idx + IDX_W'(1);
        if (r_state == S_CAPTURE && r_idx == c_last) r_status <= in_status;
      end else if (r_state == S_IDLE) begin
        r_idx <= '0;
      end
      if (w_check)     r_rd_idx <= '0;
      else if (w_xfer) r_rd_idx <= r_rd_idx + IDX_W'(1);
    end
  end

  // Pattern match over the whole buffer, then cross-check with the status.
  always_comb begin
    w_is_win  = 1'b1;
    w_is_err  = 1'b1;
    w_is_lock = 1'b1;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_buf[i] != ((i % 2 == 0) ? 8'hCE : 8'hFA)) w_is_win  = 1'b0;
      if (r_buf[i] != ((i % 2 == 0) ? 8'hD0 : 8'hBA)) w_is_err  = 1'b0;
      if (r_buf[i] != ((i % 2 == 0) ? 8'hAD : 8'hDE)) w_is_lock = 1'b0;
    end
    if      (w_is_win  && r_status == 2'b10) w_class = 3'd1;
    else if (w_is_err  && r_status == 2'b01) w_class = 3'd2;
    else if (w_is_lock && r_status == 2'b11) w_class = 3'd3;
    else                                     w_class = 3'd4;
  end

  assign w_update      = w_check | w_short;
  assign w_new_verdict = w_short ? 3'd4 : w_class;

  // Verdict register with a one-cycle pulse on each update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verdict       <= 3'd0;
      verdict_valid <= 1'b0;
    end else begin
      verdict_valid <= w_update;
      if (w_update) verdict <= w_new_verdict;
    end
  end

  // Saturating statistics and sticky overrun; a clear beats any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      err_cnt     <= '0;
      lock_cnt    <= '0;
      corrupt_cnt <= '0;
      overrun     <= 1'b0;
    end else if (clr_stats) begin
      win_cnt     <= '0;
      err_cnt     <= '0;
      lock_cnt    <= '0;
      corrupt_cnt <= '0;
      overrun     <= 1'b0;
    end else begin
      if (w_drop) overrun <= 1'b1;
      if (w_update) begin
        case (w_new_verdict)
          3'd1:    win_cnt     <= sat_inc(win_cnt);
          3'd2:    err_cnt     <= sat_inc(err_cnt);
          3'd3:    lock_cnt    <= sat_inc(lock_cnt);
          default: corrupt_cnt <= sat_inc(corrupt_cnt);
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/lockpick_result_capture.md
Name: lockpick_result_capture

Overview:
- Downstream stage of the lockpick game core.
- Consumes the core's 32-byte result burst (output_valid/output_data) together with its 2-bit status, and buffers the burst.
- Decodes and cross-checks the verdict, keeps saturating per-verdict statistics, and replays the buffered bytes to a host over a valid/ready stream.

Parameters:
- NBYTES, 32, number of bytes in one result burst; must be a multiple of 4.
- CNT_W, 8, width of each saturating statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  byte strobe from the core's output_valid.
- in_data  in  8  result byte from the core's output_data.
- in_status  in  2  core status: 00 idle, 01 error, 10 win, 11 locked out.
- out_valid  out  1  replay byte available.
- out_ready  in  1  host accepts the replay byte.
- out_data  out  8  replay byte.
- verdict_valid  out  1  one-cycle pulse when verdict is updated.
- verdict  out  3  0 none, 1 win, 2 error, 3 lockout, 4 corrupt.
- win_cnt, err_cnt, lock_cnt, corrupt_cnt  out  CNT_W each  saturating statistics counters.
- overrun  out  1  sticky flag: a byte arrived while the block could not accept it.
- clr_stats  in  1  synchronous clear of all counters and of overrun.

Behaviour:
- Reset: state IDLE, byte index 0, all outputs 0, verdict 0. Buffer contents are don't-care.
- States: IDLE, CAPTURE, CHECK, REPLAY.
- IDLE:
  - in_valid=1 stores in_data to buf[0], index=1, go to CAPTURE.
  - in_valid=0 stays in IDLE.
- CAPTURE:
  - Each cycle with in_valid=1 stores buf[index] and increments index.
  - When the byte at index NBYTES-1 is stored, in_status is sampled in the same cycle and the block goes to CHECK.
  - in_valid=0 before the burst is complete is a short burst: verdict=4, verdict_valid pulse, corrupt_cnt+1, go to IDLE, no replay.
- CHECK (exactly 1 cycle): classify the buffer.
  - Pattern WIN: every 4-byte group equals CE,FA,CE,FA (byte 0 first).
  - Pattern ERROR: D0,BA,D0,BA.
  - Pattern LOCKOUT: AD,DE,AD,DE.
  - verdict=1/2/3 only when the buffer matches that pattern AND the sampled status is 10/01/11 respectively. Any other combination gives verdict=4.
  - The matching counter increments by 1 and saturates at all-ones.
  - verdict_valid pulses high for the one cycle in which CHECK transitions to REPLAY. verdict holds its value until the next update.
- REPLAY:
  - out_valid=1 and out_data=buf[rd_index], starting at rd_index 0.
  - A byte transfers on out_valid && out_ready. While out_ready=0, out_data holds stable.
  - After the transfer of byte NBYTES-1, out_valid drops on the next cycle and the state returns to IDLE.
  - Throughput is one byte per cycle when out_ready is held high.
- Latency: the first replay byte is valid 2 cycles after the last input byte is accepted (CHECK, then REPLAY).
- Overrun: in_valid=1 while in CHECK or REPLAY drops the byte and sets overrun=1. overrun stays set until clr_stats or reset.
- clr_stats:
  - Zeroes all four counters and overrun on the next edge.
  - If it coincides with a counter increment, the clear wins.
  - It does not affect state, buffer, or verdict.
- Reset asserted mid-burst or mid-replay aborts immediately: IDLE, out_valid=0, counters 0. A partial burst is discarded and not counted.

Test Plan:
1. Burst of 32 bytes repeating CE,FA with status=10, out_ready=1 → 2 cycles later 32 replay bytes CE,FA,…, verdict=1, verdict_valid pulse, win_cnt=1.
2. BAD0 pattern with status=01, then DEADDEAD pattern with status=11 → verdicts 2 then 3, err_cnt=1, lock_cnt=1.
3. WIN pattern with status=01; separately, a burst where byte 17 is flipped to 0x00 with status=10 → verdict=4 in both cases, corrupt_cnt=2.
4. 20-byte burst, then in_valid drops → verdict=4, no out_valid, state IDLE. A following full WIN burst is captured correctly.
5. Replay with out_ready toggling 1,0,0,1 → out_data stable while stalled, all 32 bytes delivered in order. in_valid pulsed during replay → overrun=1 and the replay data is unchanged.
6. 300 WIN bursts with CNT_W=8 → win_cnt saturates at 255. clr_stats in the same cycle as an increment → 0. Reset mid-replay → out_valid=0 immediately.
